// File: rtl/bcd_ctrl_pkg.sv
// Shared types and helpers for the BCD countdown controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bcd_ctrl_pkg;

    localparam int BCD_DWL = 4;
    localparam logic [BCD_DWL-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } bcd_state_e;

    // A digit is legal BCD when it does not exceed 9.
    function automatic logic bcd_digit_ok(input logic [BCD_DWL-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while RUN is high, TICK marks the last count.
// Latency: TICK is combinational from the registered count.
// Backpressure: none; RUN low freezes the count, CLEAR forces it to zero.
module bcd_tick_gen #(
    parameter int PRESCALE = 100000
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic CLEAR,
    input  logic RUN,
    output logic TICK
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance and wrap while running, else hold.
    always_comb begin
        cnt_d = cnt_q;
        if (CLEAR) begin
            cnt_d = '0;
        end else if (RUN) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Sequencer for a chain of BCD down-counters: preset load, prescaled borrow-cascade enables, stop at zero.
// Latency: START sampled -> DIG_LOAD next cycle -> RUN with preset digits the cycle after.
// Backpressure: none; STOP pauses/aborts, optional BCD_AUTO_RELOAD_EN restarts from DONE.
module bcd_countdown_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DWL      = 4,
    parameter int NDIG     = 4,
    parameter int PRESCALE = 100000
) (
    input  logic                CLK,
    input  logic                CLR_N,
    input  logic                START,
    input  logic                STOP,
    input  logic [NDIG*DWL-1:0] PRESET,
    input  logic [NDIG*DWL-1:0] DIG_Q,
    output logic                DIG_LOAD,
    output logic [NDIG*DWL-1:0] DIG_D,
    output logic [NDIG-1:0]     DIG_ENABLE,
    output logic                DIG_UP,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);

    bcd_state_e          state_q, state_d;
    logic                dig_load_q, dig_load_d;
    logic [NDIG*DWL-1:0] dig_d_q, dig_d_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic preset_ok;
    logic allzero;
    logic tick;
    logic run_tick;

    bcd_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .CLEAR (state_q == ST_LOAD),
        .RUN   (state_q == ST_RUN),
        .TICK  (tick)
    );

    // Preset legality: every digit must be 0..9.
    always_comb begin
        preset_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!bcd_digit_ok(PRESET[i*DWL +: DWL])) begin
                preset_ok = 1'b0;
            end
        end
    end

    assign allzero  = (DIG_Q == '0);
    assign run_tick = (state_q == ST_RUN) && tick && !allzero;

    // Borrow cascade: a digit counts when every lower digit is already zero.
    always_comb begin
        logic lower_zero;
        lower_zero = 1'b1;
        DIG_ENABLE = '0;
        for (int i = 0; i < NDIG; i++) begin
            DIG_ENABLE[i] = run_tick && lower_zero;
            if (DIG_Q[i*DWL +: DWL] != '0) begin
                lower_zero = 1'b0;
            end
        end
    end

    // Control FSM; STOP has priority over START when idle, zero has priority over STOP when running.
    always_comb begin
        state_d    = state_q;
        dig_load_d = 1'b0;
        dig_d_d    = dig_d_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (START) begin
                    if (preset_ok) begin
                        dig_d_d    = PRESET;
                        err_d      = 1'b0;
                        state_d    = ST_LOAD;
                        dig_load_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
`ifdef BCD_AUTO_RELOAD_EN
                end else if (state_q == ST_DONE) begin
                    // Periodic mode: reload the held preset without user action.
                    state_d    = ST_LOAD;
                    dig_load_d = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (allzero) begin
                    state_d = ST_DONE;
                end else if (STOP) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (START) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Registered state and strobes.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q    <= ST_IDLE;
            dig_load_q <= 1'b0;
            dig_d_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig_load_q <= dig_load_d;
            dig_d_q    <= dig_d_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign DIG_LOAD = dig_load_q;
    assign DIG_D    = dig_d_q;
    assign DIG_UP   = 1'b0;
    assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Self-checking bench for bcd_countdown_ctrl with NDIG=2, PRESCALE=4 and a behavioural counter array.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_countdown_ctrl;

    localparam int NDIG = 2;
    localparam int DWL  = 4;
    localparam int PS   = 4;

    logic            CLK   = 1'b0;
    logic            CLR_N = 1'b0;
    logic            START = 1'b0;
    logic            STOP  = 1'b0;
    logic [7:0]      PRESET = 8'h00;
    logic [7:0]      DIG_Q;
    logic            DIG_LOAD;
    logic [7:0]      DIG_D;
    logic [NDIG-1:0] DIG_ENABLE;
    logic            DIG_UP;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    bcd_countdown_ctrl #(
        .DWL      (DWL),
        .NDIG     (NDIG),
        .PRESCALE (PS)
    ) dut (
        .CLK        (CLK),
        .CLR_N      (CLR_N),
        .START      (START),
        .STOP       (STOP),
        .PRESET     (PRESET),
        .DIG_Q      (DIG_Q),
        .DIG_LOAD   (DIG_LOAD),
        .DIG_D      (DIG_D),
        .DIG_ENABLE (DIG_ENABLE),
        .DIG_UP     (DIG_UP),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    // Behavioural BCD down-counter array; not reset by CLR_N.
    logic [7:0] cq = 8'h00;
    always @(posedge CLK) begin
        if (DIG_LOAD) begin
            cq <= DIG_D;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (DIG_ENABLE[i]) begin
                    cq[i*4 +: 4] <= (cq[i*4 +: 4] == 4'd0) ? 4'd9 : cq[i*4 +: 4] - 4'd1;
                end
            end
        end
    end
    assign DIG_Q = cq;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic [7:0] last_valid = 8'h00;

    typedef struct {
        logic [7:0] preset;
        bit         exp_err;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // One START pulse with the given preset, then observe until well past the expected DONE.
    task automatic run_vec(input logic [7:0] p, input bit e);
        int n, budget, loads, ens, dones, done_at, wraps;
        logic [7:0] prev;
        n = bcd2int(p);
        loads = 0; ens = 0; dones = 0; done_at = -1; wraps = 0; prev = 8'h00;
        PRESET = p;
        START  = 1'b1;
        if (!e) begin
            for (int v = n; v >= 0; v--) exp_q.push_back(v);
        end
        @(negedge CLK);
        START = 1'b0;
        chk("err_after_start", int'(ERR), int'(e));
        if (e) begin
            for (int c = 1; c <= 10; c++) begin
                if (c > 1) @(negedge CLK);
                if (DIG_LOAD) loads++;
                if (BUSY) ens++;
            end
            chk("bad_preset_no_load", loads, 0);
            chk("bad_preset_not_busy", ens, 0);
            chk("bad_preset_err_sticky", int'(ERR), 1);
            chk("bad_preset_dig_d_held", int'(DIG_D), int'(last_valid));
            return;
        end
        last_valid = p;
        budget = n * PS + 20;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge CLK);
            STOP = 1'b0;
            if (DIG_LOAD) loads++;
            if (DIG_ENABLE != '0) ens++;
            if (DIG_Q == 8'h10 && DIG_ENABLE != '0) chk("cascade_10_to_09", int'(DIG_ENABLE), 3);
            if (DIG_Q == 8'h00 && DIG_ENABLE != '0) wraps++;
            if (DONE) begin
                dones++;
                if (done_at < 0) done_at = c;
                STOP = 1'b1;   // leave DONE for IDLE in either build
            end
            if (c == 2 || (c > 2 && DIG_Q != prev)) begin
                if (exp_q.size() == 0) chk("digit_seq_extra", bcd2int(DIG_Q), -1);
                else chk("digit_seq", bcd2int(DIG_Q), exp_q.pop_front());
                prev = DIG_Q;
            end
        end
        STOP = 1'b0;
        chk("load_pulses", loads, 1);
        chk("done_latency", done_at, n * PS + 3);
        chk("done_pulses", dones, 1);
        chk("no_wrap", wraps, 0);
        chk("enable_ticks", ens, n);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_digits", int'(DIG_Q), 0);
        chk("final_busy", int'(BUSY), 0);
        exp_q.delete();
    endtask

    initial begin
        int d, bad;
        vecs[0] = '{8'h12, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'h1A, 1'b1};
        vecs[3] = '{8'h05, 1'b0};
        vecs[4] = '{8'h09, 1'b0};

        // Reset values.
        repeat (2) @(negedge CLK);
        chk("rst_dig_load", int'(DIG_LOAD), 0);
        chk("rst_dig_enable", int'(DIG_ENABLE), 0);
        chk("rst_dig_d", int'(DIG_D), 0);
        chk("rst_dig_up", int'(DIG_UP), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        CLR_N = 1'b1;
        @(negedge CLK);

        // Reset in the middle of a run.
        PRESET = 8'h25;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (8) @(negedge CLK);
        chk("midrun_busy_before", int'(BUSY), 1);
        CLR_N = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(BUSY), 0);
        chk("midrun_rst_dig_d", int'(DIG_D), 0);
        chk("midrun_rst_enable", int'(DIG_ENABLE), 0);
        chk("midrun_rst_load", int'(DIG_LOAD), 0);
        chk("midrun_rst_done", int'(DONE), 0);
        @(negedge CLK);
        CLR_N = 1'b1;
        @(negedge CLK);

        // Table-driven runs.
        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v].preset, vecs[v].exp_err);
            repeat (2) @(negedge CLK);
        end

        // Pause / resume / abort with preset 30.
        PRESET = 8'h30;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        d = 0;
        while (DIG_Q != 8'h27 && d < 200) begin
            @(negedge CLK);
            d++;
        end
        chk("reach_27", int'(DIG_Q), 8'h27);
        @(negedge CLK);          // prescaler now one count past the tick
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        chk("pause_busy", int'(BUSY), 1);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (DIG_Q != 8'h27 || DIG_ENABLE != '0) bad++;
        end
        chk("pause_frozen", bad, 0);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        d = 1;
        while (DIG_Q != 8'h26 && d < 20) begin
            @(negedge CLK);
            d++;
        end
        chk("resume_phase", d, 3);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("second_pause_busy", int'(BUSY), 1);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        repeat (5) @(negedge CLK);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_digits_kept", int'(DIG_Q), 8'h26);
        chk("abort_no_enable", int'(DIG_ENABLE), 0);

`ifdef BCD_AUTO_RELOAD_EN
        begin
            int times[4];
            int nt, loads, dones;
            nt = 0;
            PRESET = 8'h03;
            START  = 1'b1;
            @(negedge CLK);
            START = 1'b0;
            for (int c = 1; c <= 120 && nt < 4; c++) begin
                if (c > 1) @(negedge CLK);
                if (DONE) begin
                    times[nt] = c;
                    nt++;
                end
            end
            chk("reload_pulse_count", nt, 4);
            if (nt == 4) begin
                for (int i = 1; i < 4; i++) chk("reload_period", times[i] - times[i-1], 3 * PS + 3);
            end
            STOP = 1'b1;
            @(negedge CLK);
            STOP = 1'b0;
            loads = 0; dones = 0;
            for (int c = 0; c < 30; c++) begin
                if (DIG_LOAD) loads++;
                if (DONE) dones++;
                @(negedge CLK);
            end
            chk("reload_stop_no_load", loads, 0);
            chk("reload_stop_no_done", dones, 0);
            chk("reload_stop_busy", int'(BUSY), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_ctrl.md
# bcd_countdown_ctrl

Sequencing controller for a chain of NDIG BCD digit counters wired as a down-counting timer. It loads a BCD preset into the digits and generates a prescaled tick. It drives per-digit LOAD/ENABLE with borrow cascading, stops the chain at all-zero rather than wrapping, and reports completion. It sits between the user control logic (start/stop buttons, preset switches) and the instantiated BCD counter array, whose Q/CO outputs it monitors.

## Interface
Parameters:
- DWL, 4, digit width (fixed BCD; other values unsupported)
- NDIG, 4, number of cascaded digits (1..8)
- PRESCALE, 100000, CLK cycles per count tick (≥2)

Ports:
- CLK  in  1  rising-edge clock, single domain
- CLR_N  in  1  asynchronous active-low reset
- START  in  1  level, sampled each cycle: load-and-run from IDLE/DONE, resume from PAUSE
- STOP  in  1  level, sampled: pause from RUN, abort to IDLE from PAUSE
- PRESET  in  NDIG*DWL  BCD preset, digit 0 = LSD in bits [3:0]
- DIG_Q  in  NDIG*DWL  current digit values from the counter array
- DIG_LOAD  out  1  broadcast load strobe to all digits
- DIG_D  out  NDIG*DWL  load data (registered copy of PRESET)
- DIG_ENABLE  out  NDIG  per-digit count enable
- DIG_UP  out  1  direction, tied 0 (down)
- BUSY  out  1  high in LOAD, RUN, PAUSE
- DONE  out  1  one-cycle pulse on entry to DONE state
- ERR  out  1  sticky: START rejected because a PRESET digit > 9

## Operation
- FSM states: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE/DONE: START and STOP both low → stay. STOP high → IDLE (STOP wins over START). START only → if every PRESET digit ≤ 9: latch PRESET into DIG_D, clear ERR, go LOAD; else set ERR and stay.
- LOAD: DIG_LOAD=1 for exactly one cycle; prescaler cleared; → RUN.
- RUN: the prescaler counts 0..PRESCALE-1, and TICK=1 when it reaches PRESCALE-1. DIG_ENABLE[i] = RUN & TICK & ~ALLZERO & (all digits j<i equal 0). ALLZERO=1 → DONE. This takes priority over STOP. STOP → PAUSE.
- PAUSE: prescaler holds its value; DIG_ENABLE=0. STOP → IDLE (abort; digits keep their value). START → RUN, with the prescaler continuing from the held value.
- DONE: DONE output pulses on the entry cycle only; DIG_Q stays at all zero.
- DIG_D holds its last latched value; it is not cleared in IDLE.
- Digits never wrap 0→9 at the all-zero boundary, because enables are gated by ~ALLZERO.

## Timing
- Reset (CLR_N low, asynchronous): state=IDLE, prescaler=0, DIG_LOAD=0, DIG_ENABLE=0, DIG_D=0, DIG_UP=0, BUSY=0, DONE=0, ERR=0.
- State transitions, DIG_LOAD, DIG_D, DONE and ERR are registered. DIG_ENABLE is combinational from the registered state, the prescaler and DIG_Q.
- START seen at edge k → DIG_LOAD high in cycle k+1 → digits hold PRESET from cycle k+2 (RUN begins).
- A preset of value N needs N ticks. The DONE pulse occurs one cycle after the edge that makes DIG_Q zero, i.e. about N*PRESCALE+3 cycles after START.
- Preset zero: LOAD, one RUN cycle, then DONE; no enable is ever asserted.
- Reset while running: immediate return to IDLE; counter contents are external and are not cleared.

## Configuration
- BCD_AUTO_RELOAD_EN defined: from DONE, with START and STOP both low, the next state is LOAD using the held DIG_D. This gives a periodic timer, and DONE pulses once per period. STOP in DONE → IDLE.
- Undefined: DONE remains until START or STOP, as described above.

## Structure
- Package bcd_ctrl_pkg holds: the state enum (IDLE, LOAD, RUN, PAUSE, DONE), BCD_DWL=4, BCD_MAX=4'd9, and a function that checks whether a digit is valid BCD.
- Sub-module bcd_tick_gen (prescaler): inputs CLK, CLR_N, CLEAR, RUN; output TICK.
- The controller itself holds the FSM, the enable-cascade logic and the preset check.

## Test plan
All scenarios use NDIG=2 and PRESCALE=4, with a behavioural BCD counter array attached.
- Reset mid-RUN with PRESET=0x25 → all outputs return to reset values immediately; BUSY=0.
- PRESET=0x12 with a START pulse → DIG_LOAD for one cycle. Digits step through 12,11,10,09,…,00, with a tick every 4 cycles. The 10→09 step asserts DIG_ENABLE=2'b11. A single DONE pulse follows, and 00 is held with no wrap.
- PRESET=0x00 with START → DONE pulse 3 cycles after START and no DIG_ENABLE assertion.
- PRESET=0x1A with START → ERR=1, state stays IDLE, DIG_LOAD never asserted. A later START with 0x05 clears ERR and runs.
- PRESET=0x30: STOP at count 27 → PAUSE, digits frozen. START → resume from 27 with the same prescaler phase. STOP twice → IDLE with BUSY=0.
- BCD_AUTO_RELOAD_EN with PRESET=0x03 → DONE pulses periodically at a fixed interval. STOP during DONE → IDLE.
